// File: rtl/guess_entry_buffer.sv
// Collects debounced keypad presses into a DIGITS-long numeric guess and offers it to the
// game logic over a valid/ready handshake. Digits fill from the MS nibble; unfilled nibbles
// read 0xF and are flagged in digit_blank_o for the seven-segment path.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   key_pulse_i    one-cycle key strobe from the debouncer
//   key_code_i     0-9 digit, A backspace, B enter, C clear, D-F unused
//   guess_ready_i  game logic accepts the offered guess
//   guess_valid_o  guess complete and offered (held until transfer)
//   guess_o        BCD digits, first-entered digit in the MS nibble
//   digit_blank_o  bit i set when nibble i is unfilled
//   digit_count_o  number of digits entered
//   error_pulse_o  one-cycle strobe after a rejected key
module guess_entry_buffer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_pulse_i,
  input  logic [3:0]            key_code_i,
  input  logic                  guess_ready_i,
  output logic                  guess_valid_o,
  output logic [4*DIGITS-1:0]   guess_o,
  output logic [DIGITS-1:0]     digit_blank_o,
  output logic [3:0]            digit_count_o,
  output logic                  error_pulse_o
);

  typedef enum logic [1:0] {StEntry, StFull, StSubmit} state_e;

  localparam logic [3:0] CodeBksp  = 4'hA;
  localparam logic [3:0] CodeEnter = 4'hB;
  localparam logic [3:0] CodeClear = 4'hC;
  localparam logic [3:0] CountFull = 4'(DIGITS);

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] guess_q, guess_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [3:0]          count_q, count_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  // Nibble index of the next free position and of the last filled one (MS-first).
  int wr_idx;
  int bs_idx;

  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    blank_d = blank_q;
    count_d = count_q;
    valid_d = valid_q;
    error_d = 1'b0;
    wr_idx  = int'(DIGITS) - 1 - int'(count_q);
    bs_idx  = int'(DIGITS) - int'(count_q);

    case (state_q)
      StSubmit: begin
        // Buffer is frozen while offered; every key is rejected, even on the transfer edge.
        error_d = key_pulse_i;
        if (guess_ready_i) begin
          guess_d = '1;
          blank_d = '1;
          count_d = '0;
          valid_d = 1'b0;
          state_d = StEntry;
        end
      end
      default: begin
        if (key_pulse_i) begin
          if (key_code_i <= 4'd9) begin
            if (state_q == StEntry) begin
              for (int i = 0; i < int'(DIGITS); i++) begin
                if (i == wr_idx) begin
                  guess_d[4*i +: 4] = key_code_i;
                  blank_d[i]        = 1'b0;
                end
              end
              count_d = count_q + 4'd1;
              if (count_d == CountFull) state_d = StFull;
            end else begin
              error_d = 1'b1;
            end
          end else if (key_code_i == CodeBksp) begin
            if (count_q != 4'd0) begin
              for (int i = 0; i < int'(DIGITS); i++) begin
                if (i == bs_idx) begin
                  guess_d[4*i +: 4] = 4'hF;
                  blank_d[i]        = 1'b1;
                end
              end
              count_d = count_q - 4'd1;
              state_d = StEntry;
            end else begin
              error_d = 1'b1;
            end
          end else if (key_code_i == CodeEnter) begin
            if (state_q == StFull) begin
              state_d = StSubmit;
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else if (key_code_i == CodeClear) begin
            guess_d = '1;
            blank_d = '1;
            count_d = '0;
            state_d = StEntry;
          end else begin
            error_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEntry;
      guess_q <= '1;
      blank_q <= '1;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      blank_q <= blank_d;
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign guess_valid_o = valid_q;
  assign guess_o       = guess_q;
  assign digit_blank_o = blank_q;
  assign digit_count_o = count_q;
  assign error_pulse_o = error_q;

endmodule
